// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pooling over channel-major raster pixels.
// A half-width line buffer keeps horizontal pair maxima of even rows; one output register.
module maxpool2x2_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_SIZE   = 30,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned POOL_OUT   = IMG_SIZE / 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         done
);

  localparam int unsigned XW = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LW = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1;
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_SIZE - 1);
  localparam logic [XW-1:0] PAIR_LAST = XW'(2 * POOL_OUT - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);
  localparam bit            ODD       = (IMG_SIZE % 2) == 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                         state, state_next;
  logic [XW-1:0]                  x, y;
  logic [CW-1:0]                  ch;
  logic                           all_in;
  logic signed [DATA_WIDTH-1:0]   h_reg;
  logic signed [DATA_WIDTH-1:0]   line_buf [POOL_OUT];

  logic                           accept_c, discard_c, x_wrap_c, y_wrap_c, frame_end_c, load_c;
  logic [LW-1:0]                  lb_idx_c;
  logic signed [DATA_WIDTH-1:0]   pair_c, pool_c;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Input is only taken in RUN, before the frame is complete, when the output slot frees up.
  assign in_ready    = (state == S_RUN) && !all_in && (!out_valid || out_ready);
  assign accept_c    = in_valid && in_ready;
  assign x_wrap_c    = (x == X_LAST);
  assign y_wrap_c    = (y == X_LAST);
  assign discard_c   = ODD && (x_wrap_c || y_wrap_c);
  assign frame_end_c = x_wrap_c && y_wrap_c && (ch == CH_LAST);
  assign lb_idx_c    = LW'(x >> 1);
  assign pair_c      = smax(h_reg, in_data);
  assign pool_c      = smax(line_buf[lb_idx_c], pair_c);
  assign load_c      = accept_c && x[0] && y[0] && !discard_c;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; RUN ends once all input is taken and the output slot drains
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (enable) state_next = S_RUN;
      S_RUN:  if (all_in && (!out_valid || out_ready)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Counters, pair register and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      ch        <= '0;
      all_in    <= 1'b0;
      h_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state_next == S_DONE);
      if (state == S_IDLE && enable) begin
        x      <= '0;
        y      <= '0;
        ch     <= '0;
        all_in <= 1'b0;
      end else if (accept_c) begin
        if (x_wrap_c) begin
          x <= '0;
          if (y_wrap_c) begin
            y  <= '0;
            ch <= (ch == CH_LAST) ? '0 : ch + CW'(1);
          end else begin
            y <= y + XW'(1);
          end
        end else begin
          x <= x + XW'(1);
        end
        if (frame_end_c) all_in <= 1'b1;
        if (!discard_c && !x[0]) h_reg <= in_data;
      end

      if (load_c) begin
        out_valid <= 1'b1;
        out_data  <= pool_c;
        out_last  <= (ch == CH_LAST) && (x == PAIR_LAST) && (y == PAIR_LAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Line buffer holds even-row pair maxima; each entry is written before it is read
  always_ff @(posedge clk) begin
    if (accept_c && !discard_c && x[0] && !y[0]) line_buf[lb_idx_c] <= pair_c;
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: array-based pooling model, random data and back-pressure,
// mid-frame reset, enable during RUN, and an odd-size (5x5) instance.
module tb_maxpool2x2_stream;

  localparam int DW   = 16;
  localparam int IS   = 30;
  localparam int NC   = 8;
  localparam int PO   = IS / 2;
  localparam int NPIX = NC * IS * IS;
  localparam int NOUT = NC * PO * PO;

  logic clk = 1'b0;
  logic reset_n, enable, in_valid, in_ready, out_valid, out_ready, out_last, done;
  logic signed [DW-1:0] in_data, out_data;

  logic s_enable, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_done;
  logic signed [DW-1:0] s_in_data, s_out_data;

  int total = 0;
  int bad   = 0;

  int pix [NPIX];
  int exp_out [NOUT];

  bit chk_en  = 1'b0;
  bit rnd_rdy = 1'b0;
  int in_cnt, out_cnt, done_seen, pend_val;
  bit pend, done_pend, stall_prev;
  logic signed [DW-1:0] prev_data;
  logic prev_last;

  bit s_chk = 1'b0;
  int s_q[$];
  int s_last_q[$];
  int s_acc, s_done_cnt, s_acc_at_done;

  maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_SIZE(IS), .NUM_CH(NC)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done)
  );

  maxpool2x2_stream #(.DATA_WIDTH(DW), .IMG_SIZE(5), .NUM_CH(1)) dut_odd (
    .clk(clk), .reset_n(reset_n), .enable(s_enable),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .done(s_done)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Downstream back-pressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_rdy ? ($urandom_range(2) != 0) : 1'b1;
    end
  end

  // Compare process for the 30x30x8 instance
  always @(negedge clk) begin
    if (chk_en) begin
      if (pend) begin
        check(out_valid === 1'b1 && out_data == pend_val, "latency_value", int'(out_data), pend_val);
        pend = 1'b0;
      end
      if (stall_prev)
        check(out_valid === 1'b1 && out_data == prev_data && out_last == prev_last,
              "stall_hold", int'(out_data), int'(prev_data));
      if (done_pend) begin
        check(done === 1'b1, "done_timing", int'(done), 1);
        done_pend = 1'b0;
      end else begin
        check(done === 1'b0, "done_spurious", int'(done), 0);
      end
      if (done) done_seen++;
      if (out_valid && !out_ready) check(in_ready === 1'b0, "stall_in_ready", int'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (out_cnt >= NOUT) begin
          check(1'b0, "extra_output", out_cnt, NOUT - 1);
        end else begin
          check(out_data == exp_out[out_cnt], "out_data", int'(out_data), exp_out[out_cnt]);
          check(out_last == (out_cnt == NOUT - 1), "out_last", int'(out_last), int'(out_cnt == NOUT - 1));
          if (out_cnt == NOUT - 1) done_pend = 1'b1;
        end
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        int c, r, yy, xx;
        c  = in_cnt / (IS * IS);
        r  = in_cnt % (IS * IS);
        yy = r / IS;
        xx = r % IS;
        if ((yy % 2) == 1 && (xx % 2) == 1) begin
          pend     = 1'b1;
          pend_val = exp_out[c * PO * PO + (yy / 2) * PO + xx / 2];
        end
        in_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Collector for the 5x5 instance
  always @(negedge clk) begin
    if (s_chk) begin
      if (s_out_valid && s_out_ready) begin
        s_q.push_back(int'(s_out_data));
        s_last_q.push_back(int'(s_out_last));
      end
      if (s_in_valid && s_in_ready) s_acc++;
      if (s_done) begin
        s_done_cnt++;
        s_acc_at_done = s_acc;
      end
    end
  end

  // mode 0: ramp, 1: ch0 all -3 / other channels -32768 with one -1 per window, 2: random
  task automatic build_frame(input int mode);
    logic signed [DW-1:0] t;
    for (int i = 0; i < NPIX; i++) begin
      t = DW'($urandom);
      case (mode)
        0:       pix[i] = i;
        1:       pix[i] = (i < IS * IS) ? -3 : -32768;
        default: pix[i] = int'(t);
      endcase
    end
    if (mode == 1)
      for (int c = 1; c < NC; c++)
        for (int py = 0; py < PO; py++)
          for (int px = 0; px < PO; px++)
            pix[c * IS * IS + (2 * py + $urandom_range(1)) * IS + 2 * px + $urandom_range(1)] = -1;
    for (int c = 0; c < NC; c++)
      for (int py = 0; py < PO; py++)
        for (int px = 0; px < PO; px++) begin
          int m;
          m = pix[c * IS * IS + 2 * py * IS + 2 * px];
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              if (pix[c * IS * IS + (2 * py + dy) * IS + 2 * px + dx] > m)
                m = pix[c * IS * IS + (2 * py + dy) * IS + 2 * px + dx];
          exp_out[c * PO * PO + py * PO + px] = m;
        end
    if (mode == 0) begin
      check(exp_out[0] == 31, "model_ramp0", exp_out[0], 31);
      check(exp_out[1] == 33, "model_ramp1", exp_out[1], 33);
      check(exp_out[NOUT - 1] == 7199, "model_ramp_last", exp_out[NOUT - 1], 7199);
    end else if (mode == 1) begin
      check(exp_out[0] == -3, "model_signed_ch0", exp_out[0], -3);
      check(exp_out[PO * PO] == -1, "model_signed_ch1", exp_out[PO * PO], -1);
      check(exp_out[NOUT - 1] == -1, "model_signed_last", exp_out[NOUT - 1], -1);
    end
  endtask

  task automatic drive_frame(input int mode, input bit gaps, input int rst_at, input bit en_mid);
    bit hs;
    int guard;
    build_frame(mode);
    in_cnt = 0; out_cnt = 0; done_seen = 0;
    pend = 1'b0; done_pend = 1'b0; stall_prev = 1'b0;
    chk_en = 1'b1;
    check(in_ready === 1'b0, "idle_in_ready", int'(in_ready), 0);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    check(in_ready === 1'b1, "first_in_ready", int'(in_ready), 1);
    for (int i = 0; i < NPIX; i++) begin
      if (i == rst_at) begin
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check(out_valid === 1'b0, "rst_out_valid", int'(out_valid), 0);
        check(out_data == 0, "rst_out_data", int'(out_data), 0);
        check(out_last === 1'b0 && done === 1'b0, "rst_last_done", int'(out_last), 0);
        check(in_ready === 1'b0, "rst_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        return;
      end
      in_data = DW'(pix[i]);
      hs = 1'b0;
      guard = 0;
      while (!hs) begin
        in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
        enable   = en_mid && (i == 100);
        @(negedge clk);
        hs = in_valid && in_ready;
        @(posedge clk); #1;
        enable = 1'b0;
        guard++;
        if (!hs && guard > 2000) begin
          check(1'b0, "input_timeout", i, 0);
          $fatal(1, "input handshake stuck");
        end
      end
    end
    in_valid = 1'b0;
    check(in_ready === 1'b0, "in_ready_after_last", int'(in_ready), 0);
    guard = 0;
    while (done_seen == 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(done_seen == 1, "done_count", done_seen, 1);
    check(out_cnt == NOUT, "out_count", out_cnt, NOUT);
    check(in_cnt == NPIX, "in_count", in_cnt, NPIX);
    chk_en = 1'b0;
  endtask

  initial begin
    int s_exp [4];
    int s_last_exp [4];
    int guard;
    s_exp      = '{6, 8, 16, 18};
    s_last_exp = '{0, 0, 0, 1};

    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    s_enable = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check(out_valid === 1'b0, "reset_out_valid", int'(out_valid), 0);
    check(out_data == 0, "reset_out_data", int'(out_data), 0);
    check(out_last === 1'b0, "reset_out_last", int'(out_last), 0);
    check(done === 1'b0, "reset_done", int'(done), 0);
    check(in_ready === 1'b0, "reset_in_ready", int'(in_ready), 0);

    drive_frame(0, 1'b0, -1, 1'b0);
    drive_frame(1, 1'b1, -1, 1'b0);
    rnd_rdy = 1'b1;
    drive_frame(2, 1'b1, -1, 1'b0);
    drive_frame(0, 1'b0, 32, 1'b0);
    rnd_rdy = 1'b0;
    drive_frame(0, 1'b0, -1, 1'b0);
    rnd_rdy = 1'b1;
    drive_frame(2, 1'b0, -1, 1'b1);
    rnd_rdy = 1'b0;

    // 5x5 single-channel ramp: last row and column are discarded
    s_chk = 1'b1; s_acc = 0; s_done_cnt = 0; s_acc_at_done = 0;
    @(posedge clk); #1;
    s_enable = 1'b1;
    @(posedge clk); #1;
    s_enable = 1'b0;
    for (int i = 0; i < 25; i++) begin
      s_in_data  = DW'(i);
      s_in_valid = 1'b1;
      guard = 0;
      while (1) begin
        @(negedge clk);
        if (s_in_ready) break;
        guard++;
        if (guard > 100) begin
          check(1'b0, "odd_input_timeout", i, 0);
          $fatal(1, "odd instance stuck");
        end
      end
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    s_chk = 1'b0;
    check(s_q.size() == 4, "odd_out_count", s_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < s_q.size()) begin
        check(s_q[k] == s_exp[k], "odd_out_data", s_q[k], s_exp[k]);
        check(s_last_q[k] == s_last_exp[k], "odd_out_last", s_last_q[k], s_last_exp[k]);
      end else begin
        check(1'b0, "odd_out_missing", k, s_exp[k]);
      end
    end
    check(s_done_cnt == 1, "odd_done_count", s_done_cnt, 1);
    check(s_acc_at_done == 25, "odd_accepted_at_done", s_acc_at_done, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2x2/stride-2 signed max-pooling stage that consumes the feature maps produced by the convolution stage and emits pooled maps to the next conv or flatten stage. Pixels arrive one per handshake in channel-major raster order (channel, row, column), matching the flattened `f*IMG_FLAT + y*IMG_SIZE + x` layout. A half-width line buffer holds horizontal pair maxima of even rows, so no full map is stored.

## Interface
- `DATA_WIDTH`, 16, signed pixel width (in and out)
- `IMG_SIZE`, 30, input map height = width
- `NUM_CH`, 8, number of channels (maps) per frame
- `POOL_OUT`, `IMG_SIZE/2`, output map height = width (floor)
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: start pulse; sampled only in IDLE
- `in_valid` in 1: input pixel valid
- `in_ready` out 1: block accepts pixel this cycle
- `in_data` in DATA_WIDTH: signed input pixel
- `out_valid` out 1: pooled pixel valid
- `out_ready` in 1: downstream accepts pooled pixel
- `out_data` out DATA_WIDTH: signed pooled pixel
- `out_last` out 1: marks final pooled pixel of the frame
- `done` out 1: one-cycle pulse, frame complete

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=0. `enable`=1 -> RUN; clears counters x, y, ch to 0.
- RUN: input handshake when `in_valid && in_ready`; `in_ready` = `!out_valid || out_ready`. `enable` ignored.
- Per accepted pixel at (ch, y, x); counters advance x, then y, then ch; x wraps at IMG_SIZE-1, y wraps at IMG_SIZE-1.
- Even x: `h_reg` <= `in_data`.
- Odd x: `pair` = signed max(`h_reg`, `in_data`).
  - Even y: `line_buf[x/2]` <= `pair`.
  - Odd y: `out_data` <= signed max(`line_buf[x/2]`, `pair`); `out_valid` <= 1.
- Odd IMG_SIZE: pixels with x = IMG_SIZE-1 or y = IMG_SIZE-1 are accepted and discarded; they produce no output and write nothing.
- `line_buf` is POOL_OUT entries of DATA_WIDTH; not reset (every entry is written before it is read).
- Ties: either operand; the value is identical. Comparison is strictly two's-complement signed.
- `out_last`=1 with the pooled pixel at (NUM_CH-1, POOL_OUT-1, POOL_OUT-1).
- After the final input pixel of the frame is accepted, `in_ready`=0. RUN -> DONE once `out_valid`=0, i.e. the last output has been handshaked.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `reset_n` low at any time, including mid-frame: immediate return to IDLE. Partial frame is discarded.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0, state IDLE, counters 0, `h_reg`=0.
- First `in_ready`=1 in the cycle after `enable` is sampled.
- Latency: pooled pixel is valid in the cycle after the input handshake of its (odd y, odd x) pixel.
- Single output register: `out_valid`/`out_data`/`out_last` hold stable while `out_valid && !out_ready`. `in_ready` is low during such a stall.
- Simultaneous output handshake and new input producing output: accepted in the same cycle; the register reloads with no bubble, giving full throughput of 1 pixel/cycle.
- `done` rises the cycle after the final `out_valid && out_ready` handshake.
- Frame length: NUM_CH·IMG_SIZE² input pixels, NUM_CH·POOL_OUT² outputs.

## Test plan
- IMG_SIZE=4, NUM_CH=1, ramp 0..15, `out_ready`=1 -> outputs 5, 7, 13, 15; `out_last` on 15; `done` pulse one cycle later.
- IMG_SIZE=4, NUM_CH=2, ch0 all -3, ch1 values with a single -1 among -32768 per window -> outputs -3 ×4, then -1 ×4. This checks the signed compare.
- Default parameters (30×30×8), random data, `out_ready` toggling pseudo-randomly -> 1800 outputs match the reference model. No output changes while stalled; `in_ready` is low whenever `out_valid && !out_ready`.
- IMG_SIZE=5, NUM_CH=1, ramp 0..24 -> outputs 6, 8, 16, 18. Row 4 and column 4 are discarded; `done` follows 25 accepted inputs.
- Mid-frame `reset_n` low after 7 pixels -> all outputs 0 and `in_ready`=0 immediately. A new `enable` plus the ramp from test 1 reproduces 5, 7, 13, 15.
- `enable` pulsed during RUN -> no counter restart; the frame completes normally with a single `done` pulse.
